// File: rtl/adder_sched_if.sv
// Client request/response and shared-adder signals of the adder scheduler.
// slave = scheduler side, master = clients plus the adder datapath.
interface adder_sched_if #(
    parameter int WIDTH = 64
);
    logic                  flush;
    logic [1:0]            req_vld;
    logic [1:0]            req_rdy;
    logic [1:0][WIDTH-1:0] req_src0;
    logic [1:0][WIDTH-1:0] req_src1;
    logic [1:0]            req_AorS;
    logic [1:0]            req_w_inst;
    logic [1:0]            req_sign;

    logic [WIDTH-1:0]      adder_src0;
    logic [WIDTH-1:0]      adder_src1;
    logic                  adder_src0_vld;
    logic                  adder_src1_vld;
    logic                  adder_AorS;
    logic                  adder_w_inst;
    logic                  sign;
    logic                  add_req;
    logic [WIDTH-1:0]      adder_sum;
    logic                  adder_co;
    logic                  adder_sign;

    logic [1:0]            rsp_vld;
    logic [1:0]            rsp_rdy;
    logic [1:0][WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_co;
    logic [1:0]            rsp_sign;

    modport slave (
        input  flush, req_vld, req_src0, req_src1, req_AorS, req_w_inst, req_sign,
        input  adder_sum, adder_co, adder_sign, rsp_rdy,
        output req_rdy, adder_src0, adder_src1, adder_src0_vld, adder_src1_vld,
        output adder_AorS, adder_w_inst, sign, add_req,
        output rsp_vld, rsp_data, rsp_co, rsp_sign
    );

    modport master (
        output flush, req_vld, req_src0, req_src1, req_AorS, req_w_inst, req_sign,
        output adder_sum, adder_co, adder_sign, rsp_rdy,
        input  req_rdy, adder_src0, adder_src1, adder_src0_vld, adder_src1_vld,
        input  adder_AorS, adder_w_inst, sign, add_req,
        input  rsp_vld, rsp_data, rsp_co, rsp_sign
    );
endinterface

// File: rtl/adder_sched.sv
// Round-robin scheduler granting one of two clients the shared adder; result registered, 1-cycle latency.
// A client is held off while its one-entry response buffer is full and not being drained; flush blocks grants.
module adder_sched #(
    parameter int WIDTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    adder_sched_if.slave bus
);
    logic                  prio;
    logic [1:0]            elig;
    logic [1:0]            grant;
    logic                  gnt_idx;
    logic                  xfer;
    logic [1:0]            rsp_vld_q;
    logic [1:0][WIDTH-1:0] rsp_data_q;
    logic [1:0]            rsp_co_q;
    logic [1:0]            rsp_sign_q;

    // rst also gates grants so req_rdy drops the moment reset rises
    assign elig = bus.req_vld & (~rsp_vld_q | bus.rsp_rdy) & {2{~(bus.flush | rst)}};

    always_comb begin
        grant   = 2'b00;
        gnt_idx = prio;
        if (elig[prio]) begin
            grant[prio] = 1'b1;
        end else if (elig[~prio]) begin
            grant[~prio] = 1'b1;
            gnt_idx      = ~prio;
        end
    end

    assign xfer        = |grant;
    assign bus.req_rdy = grant;

    always_comb begin
        bus.adder_src0     = '0;
        bus.adder_src1     = '0;
        bus.adder_src0_vld = 1'b0;
        bus.adder_src1_vld = 1'b0;
        bus.adder_AorS     = 1'b0;
        bus.adder_w_inst   = 1'b0;
        bus.sign           = 1'b0;
        bus.add_req        = 1'b0;
        if (xfer) begin
            bus.adder_src0     = bus.req_src0[gnt_idx];
            bus.adder_src1     = bus.req_src1[gnt_idx];
            bus.adder_src0_vld = 1'b1;
            bus.adder_src1_vld = 1'b1;
            bus.adder_AorS     = bus.req_AorS[gnt_idx];
            bus.adder_w_inst   = bus.req_w_inst[gnt_idx];
            bus.sign           = bus.req_sign[gnt_idx];
            bus.add_req        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= ~gnt_idx;
        end
    end

    // a new grant reloads the buffer in the same cycle it drains (no bubble)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_co_q   <= '0;
            rsp_sign_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_vld_q[i]  <= 1'b1;
                    rsp_data_q[i] <= bus.adder_sum;
                    rsp_co_q[i]   <= bus.adder_co;
                    rsp_sign_q[i] <= bus.adder_sign;
                end else if (bus.flush || bus.rsp_rdy[i]) begin
                    rsp_vld_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_co   = rsp_co_q;
    assign bus.rsp_sign = rsp_sign_q;
endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched: grant predictor plus per-requester expected-result queues,
// with a behavioural adder closing the loop on the shared-adder port.
module tb_adder_sched;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pref;
    logic [1:0]   last_rdy;
    logic [W+1:0] q0[$];
    logic [W+1:0] q1[$];
    logic [W+1:0] mon_e;
    int           mon_n;
    logic [W+1:0] adder_r;

    always #5 clk = ~clk;

    adder_sched_if #(.WIDTH(W)) bus ();
    adder_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // {sign, carry, sum}: W ops sign-extend the low half of the sum
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub, input logic w, input logic sgn);
        logic [W:0]   full;
        logic [W:0]   ae;
        logic [W:0]   be;
        logic [W:0]   se;
        logic [W-1:0] sum;
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
        sum  = w ? {{(W/2){full[W/2-1]}}, full[W/2-1:0]} : full[W-1:0];
        ae   = {sgn & a[W-1], a};
        be   = {sgn & b[W-1], b};
        se   = sub ? ae - be : ae + be;
        return {se[W], full[W], sum};
    endfunction

    always_comb begin
        adder_r       = ref_add(bus.adder_src0, bus.adder_src1, bus.adder_AorS, bus.adder_w_inst, bus.sign);
        bus.adder_sum = adder_r[W-1:0];
        bus.adder_co  = adder_r[W];
        bus.adder_sign = adder_r[W+1];
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // monitor: every buffered response is compared when it is handed over
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mon_n = (i == 0) ? q0.size() : q1.size();
                chk("rsp_vld", W'(bus.rsp_vld[i]), W'(mon_n != 0));
                if (bus.rsp_vld[i] && bus.rsp_rdy[i] && mon_n != 0) begin
                    if (i == 0) mon_e = q0.pop_front();
                    else        mon_e = q1.pop_front();
                    chk("rsp_data", bus.rsp_data[i], mon_e[W-1:0]);
                    chk("rsp_co", W'(bus.rsp_co[i]), W'(mon_e[W]));
                    chk("rsp_sign", W'(bus.rsp_sign[i]), W'(mon_e[W+1]));
                end
            end
        end
    end

    // one clock: predict the grant from the inputs, queue the expected result
    task automatic step();
        logic [1:0]   el;
        logic [1:0]   exp_rdy;
        logic [W+1:0] r;
        int           g;
        @(negedge clk);
        #1;
        el[0] = bus.req_vld[0] && q0.size() == 0 && !bus.flush;
        el[1] = bus.req_vld[1] && q1.size() == 0 && !bus.flush;
        g = -1;
        if (el[pref]) g = pref;
        else if (el[1-pref]) g = 1 - pref;
        exp_rdy  = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        last_rdy = bus.req_rdy;
        chk("req_rdy", W'(bus.req_rdy), W'(exp_rdy));
        if (g >= 0) begin
            chk("adder_src0", bus.adder_src0, bus.req_src0[g]);
            chk("adder_src1", bus.adder_src1, bus.req_src1[g]);
            chk("adder_ctl", W'({bus.add_req, bus.adder_src0_vld, bus.adder_src1_vld,
                                 bus.adder_AorS, bus.adder_w_inst, bus.sign}),
                W'({3'b111, bus.req_AorS[g], bus.req_w_inst[g], bus.req_sign[g]}));
            r = ref_add(bus.req_src0[g], bus.req_src1[g], bus.req_AorS[g], bus.req_w_inst[g], bus.req_sign[g]);
            if (g == 0) q0.push_back(r);
            else        q1.push_back(r);
            pref = 1 - g;
        end else begin
            chk("adder_idle", bus.adder_src0 | bus.adder_src1 |
                W'({bus.add_req, bus.adder_src0_vld, bus.adder_src1_vld,
                    bus.adder_AorS, bus.adder_w_inst, bus.sign}), '0);
        end
        if (bus.flush) begin
            q0.delete();
            q1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic w, input logic sg);
        bus.req_src0[i]   = a;
        bus.req_src1[i]   = b;
        bus.req_AorS[i]   = s;
        bus.req_w_inst[i] = w;
        bus.req_sign[i]   = sg;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 2; i++) begin
            set_op(i, {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        bus.req_vld = 2'($urandom_range(0, 3));
        bus.rsp_rdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
        bus.flush   = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        rst         = 1'b1;
        pref        = 0;
        bus.flush   = 1'b0;
        bus.req_vld = 2'b00;
        bus.rsp_rdy = 2'b11;
        set_op(0, '0, '0, 1'b0, 1'b0, 1'b0);
        set_op(1, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_vld", W'(bus.rsp_vld), '0);
        chk("reset_rsp_data0", bus.rsp_data[0], '0);
        chk("reset_rsp_data1", bus.rsp_data[1], '0);
        chk("reset_rsp_co_sign", W'({bus.rsp_co, bus.rsp_sign}), '0);
        chk("reset_req_rdy", W'(bus.req_rdy), '0);
        chk("reset_add_req", W'(bus.add_req), '0);
        rst = 1'b0;

        // contention straight out of reset alternates 0,1,0,1
        set_rand();
        bus.flush   = 1'b0;
        bus.req_vld = 2'b11;
        bus.rsp_rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("contention_grant", W'(last_rdy), (k % 2 == 0) ? W'(2'b01) : W'(2'b10));
        end

        set_op(0, 64'd5, 64'd3, 1'b0, 1'b0, 1'b0);
        bus.req_vld = 2'b01;
        step();
        chk("single_add_rdy", W'(last_rdy), W'(2'b01));
        chk("single_add_vld", W'(bus.rsp_vld), W'(2'b01));
        chk("single_add_data", bus.rsp_data[0], 64'd8);
        chk("single_add_co", W'(bus.rsp_co[0]), '0);

        set_op(1, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0);
        bus.req_vld = 2'b10;
        step();
        chk("w_op_data", bus.rsp_data[1], 64'hFFFF_FFFF_8000_0000);

        set_op(0, 64'd3, 64'd5, 1'b1, 1'b0, 1'b0);
        bus.req_vld = 2'b01;
        step();
        chk("sub_data", bus.rsp_data[0], 64'hFFFF_FFFF_FFFF_FFFE);

        bus.req_vld = 2'b00;
        step();

        // stalled response 0: requester 1 keeps the adder, then pass-through on 0
        bus.req_vld = 2'b11;
        bus.rsp_rdy = 2'b10;
        step(); chk("bp_a", W'(last_rdy), W'(2'b10));
        step(); chk("bp_b", W'(last_rdy), W'(2'b01));
        step(); chk("bp_c", W'(last_rdy), W'(2'b10));
        step(); chk("bp_d", W'(last_rdy), W'(2'b10));
        bus.rsp_rdy = 2'b11;
        step(); chk("bp_passthru", W'(last_rdy), W'(2'b01));

        bus.rsp_rdy = 2'b00;
        step(); chk("fill_1", W'(last_rdy), W'(2'b10));
        step(); chk("fill_none", W'(last_rdy), W'(2'b00));
        chk("both_pending", W'(bus.rsp_vld), W'(2'b11));
        bus.flush   = 1'b1;
        bus.rsp_rdy = 2'b01;
        step();
        chk("flush_rdy", W'(last_rdy), W'(2'b00));
        chk("flush_rsp_vld", W'(bus.rsp_vld), W'(2'b00));

        bus.flush   = 1'b0;
        bus.rsp_rdy = 2'b00;
        step(); chk("pre_rst_a", W'(last_rdy), W'(2'b01));
        step(); chk("pre_rst_b", W'(last_rdy), W'(2'b10));
        chk("pre_rst_vld", W'(bus.rsp_vld), W'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", W'(bus.rsp_vld), '0);
        chk("mid_rst_data0", bus.rsp_data[0], '0);
        chk("mid_rst_data1", bus.rsp_data[1], '0);
        chk("mid_rst_rdy", W'(bus.req_rdy), '0);
        q0.delete();
        q1.delete();
        pref = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_rdy = 2'b11;
        step();
        chk("post_rst_grant", W'(last_rdy), W'(2'b01));

        for (int n = 0; n < 600; n++) begin
            set_rand();
            step();
        end

        bus.flush   = 1'b0;
        bus.req_vld = 2'b00;
        bus.rsp_rdy = 2'b11;
        step();
        step();
        chk("sb_empty", W'(q0.size() + q1.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
